// File: rtl/ws2812_stream_tx.sv
// WS2812/SK6812 chain driver: pixels arrive on a valid/ready stream and are
// serialised MSB-first with programmable bit timing, latch gap and stall abort.
module ws2812_stream_tx #(
    parameter int CLK_FRE  = 50_000_000,
    parameter int LED_NUM  = 64,
    parameter int BPP      = 24,
    parameter int T0H_NS   = 400,
    parameter int T0L_NS   = 850,
    parameter int T1H_NS   = 800,
    parameter int T1L_NS   = 450,
    parameter int LATCH_US = 300,
    parameter int STALL_US = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           pix_valid,
    output logic           pix_ready,
    input  logic [BPP-1:0] pix_data,
    output logic           busy,
    output logic           frame_done,
    output logic           underrun,
    output logic           ws_dout,
    output logic [2:0]     dbg_state_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CPU   = CLK_FRE / 1_000_000;
    localparam int T0H   = CPU * T0H_NS / 1000;
    localparam int T0L   = CPU * T0L_NS / 1000;
    localparam int T1H   = CPU * T1H_NS / 1000;
    localparam int T1L   = CPU * T1L_NS / 1000;
    localparam int LATCH = CPU * LATCH_US;
    localparam int STALL = CPU * STALL_US;
    localparam int TMAX  = max2(max2(max2(T0H, T0L), max2(T1H, T1L)), max2(LATCH, STALL));
    localparam int TW    = $clog2(TMAX + 1);
    localparam int BW    = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int IW    = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

    localparam logic [TW-1:0] T0H_M1   = TW'(T0H - 1);
    localparam logic [TW-1:0] T0L_M1   = TW'(T0L - 1);
    localparam logic [TW-1:0] T1H_M1   = TW'(T1H - 1);
    localparam logic [TW-1:0] T1L_M1   = TW'(T1L - 1);
    localparam logic [TW-1:0] LATCH_M1 = TW'(LATCH - 1);
    localparam logic [TW-1:0] STALL_M1 = TW'(STALL - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BPP - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(LED_NUM - 1);

    // Handshake: a pixel moves on a rising clk edge where pix_valid and pix_ready
    // are both high; pix_ready is high only in LOAD, and pix_valid may wait freely.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        LATCH_S = 3'd4
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tmr_q;
    logic [BPP-1:0]  shift_q;
    logic [BW-1:0]   bit_q;
    logic [IW-1:0]   idx_q;
    logic            ws_dout_q;
    logic            pix_ready_q;
    logic            busy_q;
    logic            frame_done_q;
    logic            underrun_q;
    logic [TW-1:0]   hi_last_d;
    logic [TW-1:0]   lo_last_d;

    assign hi_last_d = shift_q[BPP-1] ? T1H_M1 : T0H_M1;
    assign lo_last_d = shift_q[BPP-1] ? T1L_M1 : T0L_M1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            shift_q      <= '0;
            bit_q        <= '0;
            idx_q        <= '0;
            ws_dout_q    <= 1'b0;
            pix_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= LOAD;
                        idx_q       <= '0;
                        tmr_q       <= '0;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (pix_valid && pix_ready_q) begin
                        shift_q     <= pix_data;
                        bit_q       <= '0;
                        tmr_q       <= '0;
                        pix_ready_q <= 1'b0;
                        ws_dout_q   <= 1'b1;
                        state_q     <= HIGH;
                    end else if (idx_q != '0) begin
                        // The first pixel of a frame may wait forever; later ones abort on stall.
                        if (tmr_q == STALL_M1) begin
                            underrun_q  <= 1'b1;
                            pix_ready_q <= 1'b0;
                            tmr_q       <= '0;
                            state_q     <= LATCH_S;
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (tmr_q == hi_last_d) begin
                        tmr_q     <= '0;
                        ws_dout_q <= 1'b0;
                        state_q   <= LOW;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                LOW: begin
                    if (tmr_q == lo_last_d) begin
                        tmr_q <= '0;
                        if (bit_q != BIT_LAST) begin
                            bit_q     <= bit_q + 1'b1;
                            shift_q   <= {shift_q[BPP-2:0], 1'b0};
                            ws_dout_q <= 1'b1;
                            state_q   <= HIGH;
                        end else if (idx_q != IDX_LAST) begin
                            idx_q       <= idx_q + 1'b1;
                            pix_ready_q <= 1'b1;
                            state_q     <= LOAD;
                        end else begin
                            state_q <= LATCH_S;
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                LATCH_S: begin
                    // The frame_done cycle is spent still in LATCH so a start there is ignored.
                    if (frame_done_q) begin
                        state_q <= IDLE;
                    end else if (tmr_q == LATCH_M1) begin
                        tmr_q        <= '0;
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ws_dout_q   <= 1'b0;
                    pix_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign ws_dout     = ws_dout_q;
    assign pix_ready   = pix_ready_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Directed bench for ws2812_stream_tx: measures every high/low run on the data
// line and compares it with a scoreboard built from the pixel words.
module tb_ws2812_stream_tx;

  localparam logic [31:0] T0H = 32'd20;
  localparam logic [31:0] T0L = 32'd42;
  localparam logic [31:0] T1H = 32'd40;
  localparam logic [31:0] T1L = 32'd22;
  localparam logic [31:0] LATCH = 32'd15000;
  localparam logic [31:0] STALL = 32'd1000;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic pix_valid;
  logic [31:0] pix_data;
  logic sel;

  logic ready24, busy24, fd24, ur24, dout24;
  logic ready32, busy32, fd32, ur32, dout32;
  logic [2:0] st24, st32;

  logic start24, start32, valid24, valid32;
  logic mon_dout, mon_fd, mon_ur, mon_ready, mon_busy;

  assign start24 = start & ~sel;
  assign start32 = start & sel;
  assign valid24 = pix_valid & ~sel;
  assign valid32 = pix_valid & sel;
  assign mon_dout  = sel ? dout32  : dout24;
  assign mon_fd    = sel ? fd32    : fd24;
  assign mon_ur    = sel ? ur32    : ur24;
  assign mon_ready = sel ? ready32 : ready24;
  assign mon_busy  = sel ? busy32  : busy24;

  ws2812_stream_tx #(.LED_NUM(2), .BPP(24)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .start(start24), .pix_valid(valid24),
    .pix_ready(ready24), .pix_data(pix_data[23:0]), .busy(busy24),
    .frame_done(fd24), .underrun(ur24), .ws_dout(dout24), .dbg_state_o(st24)
  );

  ws2812_stream_tx #(.LED_NUM(1), .BPP(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .pix_valid(valid32),
    .pix_ready(ready32), .pix_data(pix_data), .busy(busy32),
    .frame_done(fd32), .underrun(ur32), .ws_dout(dout32), .dbg_state_o(st32)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  logic [31:0] obs_hi_q[$];
  logic [31:0] obs_lo_q[$];
  logic [31:0] exp_tail;
  int n_checks = 0;
  int n_errors = 0;

  // line monitor, sampled on the falling edge
  logic prev_dout = 1'b0;
  logic seen_hi = 1'b0;
  int run_len = 0;
  int tail_low = 0;
  int fd_cnt = 0;
  int ur_cnt = 0;
  int ready_cnt = 0;
  int ready_at_ur = 0;
  int xfer_cnt = 0;

  always @(negedge clk) begin
    if (mon_dout != prev_dout) begin
      if (prev_dout) obs_hi_q.push_back(run_len);
      else if (seen_hi) obs_lo_q.push_back(run_len);
      if (mon_dout) seen_hi = 1'b1;
      run_len = 1;
    end else begin
      run_len = run_len + 1;
    end
    prev_dout = mon_dout;
    if (mon_fd) begin
      fd_cnt = fd_cnt + 1;
      tail_low = run_len - 1;
    end
    if (mon_ur) begin
      ur_cnt = ur_cnt + 1;
      ready_at_ur = ready_cnt;
    end
    if (mon_ready) ready_cnt = ready_cnt + 1;
    if (mon_ready && pix_valid) xfer_cnt = xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    obs_hi_q.delete();
    obs_lo_q.delete();
    seen_hi = 1'b0;
    fd_cnt = 0;
    ur_cnt = 0;
    ready_cnt = 0;
    ready_at_ur = 0;
    xfer_cnt = 0;
    tail_low = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks (all called aligned to 1 ns after a rising edge)
  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [31:0] d, input int delay);
    logic rdy, vld, done;
    int waited;
    pix_data = d;
    pix_valid = (delay == 0);
    waited = 0;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      rdy = mon_ready;
      vld = pix_valid;
      tick(1);
      if (rdy && vld) done = 1'b1;
      else if (rdy) begin
        waited++;
        if (waited >= delay) pix_valid = 1'b1;
      end
    end
    pix_valid = 1'b0;
    check("pixel_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_fd(input int limit);
    int c;
    c = 0;
    while (!mon_fd && c < limit) begin
      tick(1);
      c++;
    end
  endtask

  // expected bit timings for one frame of one or two pixels
  task automatic push_frame(input logic [31:0] p0, input logic [31:0] p1,
                            input int nbits, input int npix, input int gap);
    logic [31:0] px;
    logic b;
    exp_hi_q.delete();
    exp_lo_q.delete();
    for (int p = 0; p < npix; p++) begin
      px = (p == 0) ? p0 : p1;
      for (int i = nbits - 1; i >= 0; i--) begin
        b = px[i];
        exp_hi_q.push_back(b ? T1H : T0H);
        if (p == npix - 1 && i == 0) exp_tail = (b ? T1L : T0L) + LATCH;
        else if (i == 0) exp_lo_q.push_back((b ? T1L : T0L) + gap + 1);
        else exp_lo_q.push_back(b ? T1L : T0L);
      end
    end
  endtask

  task automatic compare_frame(input string tname);
    check({tname, "_hi_count"}, obs_hi_q.size(), exp_hi_q.size());
    check({tname, "_lo_count"}, obs_lo_q.size(), exp_lo_q.size());
    foreach (exp_hi_q[i])
      if (i < obs_hi_q.size()) check($sformatf("%s_hi[%0d]", tname, i), obs_hi_q[i], exp_hi_q[i]);
    foreach (exp_lo_q[i])
      if (i < obs_lo_q.size()) check($sformatf("%s_lo[%0d]", tname, i), obs_lo_q[i], exp_lo_q[i]);
    check({tname, "_tail_low"}, tail_low, exp_tail);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    sel = 1'b0;
    tick(3);
    check("rst_dout", {31'd0, dout24}, 32'd0);
    check("rst_ready", {31'd0, ready24}, 32'd0);
    check("rst_busy", {31'd0, busy24}, 32'd0);
    check("rst_done", {31'd0, fd24}, 32'd0);
    check("rst_underrun", {31'd0, ur24}, 32'd0);
    check("rst_state", {29'd0, st24}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // reset in the middle of a high phase
    clear_mon();
    do_start();
    send_pixel(32'h80_0001, 0);
    tick(5);
    check("t1_high_before_reset", {31'd0, dout24}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_dout_async", {31'd0, dout24}, 32'd0);
    check("t1_busy_async", {31'd0, busy24}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check("t1_state_idle", {29'd0, st24}, 32'd0);
    check("t1_busy", {31'd0, busy24}, 32'd0);
    check("t1_dout", {31'd0, dout24}, 32'd0);
    check("t1_no_done", fd_cnt, 32'd0);

    // two pixels back to back, with stray starts during HIGH, LATCH and the done cycle
    clear_mon();
    push_frame(32'h80_0001, 32'h00_0000, 24, 2, 0);
    do_start();
    fork
      begin
        send_pixel(32'h80_0001, 0);
        send_pixel(32'h00_0000, 0);
      end
      begin
        for (int c = 0; c < 100 && !dout24; c++) tick(1);
        tick(3);
        check("t5_in_high", {31'd0, dout24}, 32'd1);
        do_start();
      end
    join
    for (int c = 0; c < 5000 && obs_hi_q.size() < 48; c++) tick(1);
    tick(100);
    check("t5_in_latch", {29'd0, st24}, 32'd4);
    do_start();
    wait_fd(25000);
    check("t5_done_seen", {31'd0, fd24}, 32'd1);
    check("t5_busy_at_done", {31'd0, busy24}, 32'd0);
    do_start();
    tick(200);
    compare_frame("t2");
    check("t2_done_count", fd_cnt, 32'd1);
    check("t2_transfers", xfer_cnt, 32'd2);
    check("t5_ready_cycles", ready_cnt, 32'd2);
    check("t5_busy_after", {31'd0, busy24}, 32'd0);
    check("t2_underrun", ur_cnt, 32'd0);

    // 500-cycle pause before the second pixel
    clear_mon();
    push_frame(32'hA5_5AC3, 32'h3C_0081, 24, 2, 500);
    do_start();
    send_pixel(32'hA5_5AC3, 0);
    send_pixel(32'h3C_0081, 500);
    wait_fd(25000);
    tick(2);
    compare_frame("t3");
    check("t3_done_count", fd_cnt, 32'd1);
    check("t3_transfers", xfer_cnt, 32'd2);
    check("t3_underrun", ur_cnt, 32'd0);

    // second pixel never arrives: stall abort
    clear_mon();
    push_frame(32'h00_00FF, 32'h0, 24, 1, 0);
    exp_tail = T1L + STALL + LATCH;
    do_start();
    send_pixel(32'h00_00FF, 0);
    wait_fd(25000);
    tick(2);
    compare_frame("t4");
    check("t4_underrun_count", ur_cnt, 32'd1);
    check("t4_ready_at_underrun", ready_at_ur, 32'd1 + STALL);
    check("t4_done_count", fd_cnt, 32'd1);
    check("t4_transfers", xfer_cnt, 32'd1);
    check("t4_busy", {31'd0, busy24}, 32'd0);
    check("t4_ready", {31'd0, ready24}, 32'd0);

    // 32-bit instance, single LED, all ones
    check("t6_idle_before", {31'd0, busy32}, 32'd0);
    sel = 1'b1;
    tick(2);
    clear_mon();
    push_frame(32'hFFFF_FFFF, 32'h0, 32, 1, 0);
    do_start();
    send_pixel(32'hFFFF_FFFF, 0);
    wait_fd(25000);
    tick(2);
    compare_frame("t6");
    check("t6_done_count", fd_cnt, 32'd1);
    check("t6_transfers", xfer_cnt, 32'd1);
    check("t6_underrun", ur_cnt, 32'd0);
    check("t6_busy", {31'd0, busy32}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
